hashchecker_arbiter: RTL and testbench

- Sequences the shared hashchecker and time-shares it between one target-hash loader and N_REQ candidate-hash requesters (MD4 cracking cores).
- Converts valid/ready requests into the hashchecker strobe protocol: a newrdy strobe to store a hash, or a checkrdy strobe followed by a wait for resultrdy to check one.
- Returns one tagged result per check.
- Sits between the cracker core array and the single hashchecker instance.

---
 rtl/hashchecker_arbiter_pkg.sv | 25 ++
 rtl/hashchecker_arbiter_rr_arbiter.sv | 44 ++++
 rtl/hashchecker_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_hashchecker_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hashchecker_arbiter_pkg.sv
// Shared types and helpers for the hashchecker arbiter: FSM state encoding,
// hash width and the per-requester hash slicer.
package hashchecker_arbiter_pkg;

    localparam int HASH_W  = 128;
    localparam int MAX_REQ = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ST_STROBE = 3'd1,
        ST_SETTLE = 3'd2,
        CK_STROBE = 3'd3,
        CK_WAIT   = 3'd4,
        RESPOND   = 3'd5
    } state_t;

    // The bus is padded to MAX_REQ lanes so one signature serves every N_REQ.
    function automatic logic [HASH_W-1:0] hash_slice(
        input logic [MAX_REQ*HASH_W-1:0] bus,
        input int                        idx
    );
        return bus[idx*HASH_W +: HASH_W];
    endfunction

endpackage

// File: rtl/hashchecker_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping around, reported as a one-hot grant plus its index.
module hashchecker_arbiter_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  winner,
    output logic             any
);

    // rot_req[k] is the request k positions above the pointer.
    logic [N_REQ-1:0] rot_req;
    logic [ID_W-1:0]  rot_idx [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_rot
            logic [ID_W:0] sum;
            assign sum          = {1'b0, ptr} + (ID_W+1)'(gi);
            assign rot_idx[gi]  = (sum >= (ID_W+1)'(N_REQ)) ? ID_W'(sum - (ID_W+1)'(N_REQ))
                                                             : sum[ID_W-1:0];
            assign rot_req[gi]  = req[rot_idx[gi]];
        end
    endgenerate

    always_comb begin
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        for (int k = N_REQ-1; k >= 0; k--) begin
            if (rot_req[k]) begin
                any    = 1'b1;
                winner = rot_idx[k];
            end
        end
        if (any) begin
            grant[winner] = 1'b1;
        end
    end

endmodule

// File: rtl/hashchecker_arbiter.sv
// Time-shares one hashchecker between a target loader and N_REQ candidate
// requesters, translating valid/ready into the newrdy/checkrdy strobe protocol.
module hashchecker_arbiter
    import hashchecker_arbiter_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int ID_W           = 2,
    parameter int STROBE_CYCLES  = 2,
    parameter int SETTLE_CYCLES  = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    ld_valid,
    input  logic [HASH_W-1:0]       ld_hash,
    output logic                    ld_ready,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*HASH_W-1:0] req_hash,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    rsp_match,
    output logic                    rsp_timeout,
    output logic                    hc_newrdy,
    output logic                    hc_checkrdy,
    output logic [HASH_W-1:0]       hc_hash,
    input  logic                    hc_resultrdy,
    input  logic                    hc_matchfound,
    output logic                    busy,
    output logic [15:0]             match_count
);

    localparam logic [15:0] STROBE_LAST  = 16'(STROBE_CYCLES - 1);
    localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t              state_reg, state_next;
    logic [15:0]         cnt_reg, cnt_next;
    logic [ID_W-1:0]     ptr_reg;
    logic [ID_W-1:0]     cap_id_reg;
    logic [HASH_W-1:0]   hash_reg;
    logic                ld_ready_reg;
    logic [N_REQ-1:0]    req_ready_reg;
    logic [ID_W-1:0]     rsp_id_reg;
    logic                rsp_match_reg;
    logic                rsp_timeout_reg;
    logic [15:0]         match_count_reg;

    logic                take_ld, take_req, finish_check, result_hit;
    logic [N_REQ-1:0]    grant;
    logic [ID_W-1:0]     winner;
    logic                any_req;
    logic [MAX_REQ*HASH_W-1:0] req_hash_pad;

    hashchecker_arbiter_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_arbiter (
        .req    (req_valid),
        .ptr    (ptr_reg),
        .grant  (grant),
        .winner (winner),
        .any    (any_req)
    );

    always_comb begin
        req_hash_pad = '0;
        req_hash_pad[N_REQ*HASH_W-1:0] = req_hash;
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        take_ld      = 1'b0;
        take_req     = 1'b0;
        finish_check = 1'b0;
        result_hit   = 1'b0;
        hc_newrdy    = (state_reg == ST_STROBE);
        hc_checkrdy  = (state_reg == CK_STROBE);
        rsp_valid    = (state_reg == RESPOND);
        busy         = (state_reg != IDLE);
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (ld_valid) begin
                    take_ld    = 1'b1;
                    state_next = ST_STROBE;
                end else if (any_req) begin
                    take_req   = 1'b1;
                    state_next = CK_STROBE;
                end
            end
            ST_STROBE: begin
                if (cnt_reg == STROBE_LAST) begin
                    cnt_next   = '0;
                    state_next = (SETTLE_CYCLES == 0) ? IDLE : ST_SETTLE;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            ST_SETTLE: begin
                if (cnt_reg == SETTLE_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            CK_STROBE: begin
                if (cnt_reg == STROBE_LAST) begin
                    cnt_next   = '0;
                    state_next = CK_WAIT;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            CK_WAIT: begin
                // A result arriving on the last permitted cycle still wins over the timeout.
                if (hc_resultrdy) begin
                    finish_check = 1'b1;
                    result_hit   = 1'b1;
                    cnt_next     = '0;
                    state_next   = RESPOND;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    finish_check = 1'b1;
                    cnt_next     = '0;
                    state_next   = RESPOND;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            RESPOND: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            ptr_reg         <= '0;
            cap_id_reg      <= '0;
            hash_reg        <= '0;
            ld_ready_reg    <= 1'b0;
            req_ready_reg   <= '0;
            rsp_id_reg      <= '0;
            rsp_match_reg   <= 1'b0;
            rsp_timeout_reg <= 1'b0;
            match_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            ld_ready_reg  <= take_ld;
            req_ready_reg <= take_req ? grant : '0;
            if (take_ld) begin
                hash_reg <= ld_hash;
            end
            if (take_req) begin
                hash_reg   <= hash_slice(req_hash_pad, int'(winner));
                cap_id_reg <= winner;
                ptr_reg    <= (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
            end
            if (finish_check) begin
                rsp_id_reg      <= cap_id_reg;
                rsp_match_reg   <= result_hit & hc_matchfound;
                rsp_timeout_reg <= ~result_hit;
                if (result_hit && hc_matchfound && (match_count_reg != 16'hFFFF)) begin
                    match_count_reg <= match_count_reg + 16'd1;
                end
            end
        end
    end

    assign ld_ready    = ld_ready_reg;
    assign req_ready   = req_ready_reg;
    assign rsp_id      = rsp_id_reg;
    assign rsp_match   = rsp_match_reg;
    assign rsp_timeout = rsp_timeout_reg;
    assign hc_hash     = hash_reg;
    assign match_count = match_count_reg;

endmodule

// File: tb/tb_hashchecker_arbiter.sv
// Scoreboard bench: a stub hashchecker, a reference arbiter model and a
// response monitor check the arbiter under directed and random traffic.
`timescale 1ns/1ps
module tb_hashchecker_arbiter;

    localparam int N      = 4;
    localparam int IDW    = 2;
    localparam int STROBE = 2;
    localparam int SETTLE = 1;
    localparam int TMO    = 8;

    logic             clk = 1'b0;
    logic             nrst = 1'b0;
    logic             ld_valid = 1'b0;
    logic [127:0]     ld_hash = '0;
    logic             ld_ready;
    logic [N-1:0]     req_valid = '0;
    logic [N*128-1:0] req_hash = '0;
    logic [N-1:0]     req_ready;
    logic             rsp_valid;
    logic [IDW-1:0]   rsp_id;
    logic             rsp_match, rsp_timeout;
    logic             hc_newrdy, hc_checkrdy;
    logic [127:0]     hc_hash;
    logic             hc_resultrdy = 1'b0;
    logic             hc_matchfound = 1'b0;
    logic             busy;
    logic [15:0]      match_count;

    hashchecker_arbiter #(
        .N_REQ(N), .ID_W(IDW), .STROBE_CYCLES(STROBE),
        .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .nrst(nrst),
        .ld_valid(ld_valid), .ld_hash(ld_hash), .ld_ready(ld_ready),
        .req_valid(req_valid), .req_hash(req_hash), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_match(rsp_match), .rsp_timeout(rsp_timeout),
        .hc_newrdy(hc_newrdy), .hc_checkrdy(hc_checkrdy), .hc_hash(hc_hash),
        .hc_resultrdy(hc_resultrdy), .hc_matchfound(hc_matchfound),
        .busy(busy), .match_count(match_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           match;
        logic           tmo;
    } exp_t;

    exp_t          sb[$];
    logic [127:0]  targets[$];
    logic [127:0]  hc_store[$];
    int            grant_log[$];
    int            checks = 0, failures = 0;
    int            cyc = 0;
    int            ptr_m = 0, grants = 0, exp_rsp_cyc = 0;
    int            mc_model = 0;
    bit            exp_rsp_set = 0, hc_dead = 0, keep_all = 0, rand_mode = 0;
    bit            pend[N];
    logic [127:0]  hold[N];
    bit            ld_pend = 0;
    logic [127:0]  ld_hold = '0;
    logic [N-1:0]  drv_valid = '0;
    bit            drv_ld = 0;
    logic [127:0]  drv_ld_hash = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic bit in_list(input logic [127:0] h, input bit use_store);
        if (use_store) begin
            foreach (hc_store[i]) if (hc_store[i] == h) return 1'b1;
        end else begin
            foreach (targets[i]) if (targets[i] == h) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit any_pend();
        for (int i = 0; i < N; i++) if (pend[i]) return 1'b1;
        return ld_pend;
    endfunction

    // Stub hashchecker: records stores, answers checks after a random delay,
    // and toggles resultrdy as noise during checkrdy (must be ignored).
    logic         prev_new = 1'b0, prev_chk = 1'b0;
    bit           hc_wait = 0;
    int           hc_lat = 0;
    logic [127:0] hc_chk_hash = '0;
    always @(negedge clk) begin
        hc_resultrdy  = 1'b0;
        hc_matchfound = 1'b0;
        if (hc_newrdy && !prev_new) hc_store.push_back(hc_hash);
        if (hc_checkrdy && !prev_chk) begin
            hc_chk_hash = hc_hash;
            hc_wait     = 0;
        end
        if (hc_checkrdy && !hc_dead) begin
            hc_resultrdy  = 1'($urandom_range(0, 1));
            hc_matchfound = 1'($urandom_range(0, 1));
        end
        if (!hc_checkrdy && prev_chk) begin
            hc_wait     = 1;
            hc_lat      = $urandom_range(0, 5);
            exp_rsp_cyc = cyc + (hc_dead ? TMO : hc_lat + 1);
            exp_rsp_set = 1;
        end
        if (hc_wait && !hc_dead) begin
            if (hc_lat == 0) begin
                hc_resultrdy  = 1'b1;
                hc_matchfound = in_list(hc_chk_hash, 1'b1);
                hc_wait       = 0;
            end else begin
                hc_lat--;
            end
        end
        prev_new = hc_newrdy;
        prev_chk = hc_checkrdy;
    end

    // Protocol and response monitor.
    int           new_run = 0, chk_run = 0, settle_post = -1;
    logic         m_prev_new = 1'b0, m_prev_chk = 1'b0, prev_ldr = 1'b0;
    logic [N-1:0] prev_rr = '0;
    logic [127:0] prev_hash = '0, ck_hold = '0;
    always @(negedge clk) begin
        exp_t e;
        chk("strobes_exclusive", 128'(hc_newrdy & hc_checkrdy), 128'd0);
        if (ld_ready || (req_ready != 0))
            chk("ready_single_pulse", 128'((ld_ready & prev_ldr) | (|(req_ready & prev_rr))), 128'd0);
        if (ld_ready) chk("ld_starts_store", 128'({hc_newrdy, hc_checkrdy}), 128'b10);
        if (req_ready != 0) chk("grant_starts_check", 128'({hc_newrdy, hc_checkrdy}), 128'b01);
        if (hc_newrdy) begin
            new_run++;
            if (m_prev_new) chk("newrdy_hash_stable", hc_hash, prev_hash);
        end else if (m_prev_new) begin
            chk("newrdy_len", 128'(new_run), 128'(STROBE));
            new_run     = 0;
            settle_post = 0;
        end
        if (settle_post >= 0 && !hc_newrdy) begin
            if (settle_post < SETTLE) begin
                chk("settle_busy", 128'(busy), 128'd1);
                settle_post++;
            end else begin
                chk("idle_after_settle", 128'(busy), 128'd0);
                settle_post = -1;
            end
        end
        if (hc_checkrdy) begin
            chk_run++;
            if (!m_prev_chk) ck_hold = hc_hash;
            else chk("checkrdy_hash_stable", hc_hash, prev_hash);
        end else if (m_prev_chk) begin
            chk("checkrdy_len", 128'(chk_run), 128'(STROBE));
            chk_run = 0;
        end
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 128'(rsp_valid), 128'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_id", 128'(rsp_id), 128'(e.id));
                chk("rsp_match", 128'(rsp_match), 128'(e.match));
                chk("rsp_timeout", 128'(rsp_timeout), 128'(e.tmo));
                chk("hash_held_to_rsp", hc_hash, ck_hold);
                if (e.match && mc_model != 16'hFFFF) mc_model++;
                chk("match_count", 128'(match_count), 128'(mc_model));
                if (exp_rsp_set) chk("rsp_latency", 128'(cyc), 128'(exp_rsp_cyc));
                exp_rsp_set = 0;
                $display("rsp    id=%0d match=%0b timeout=%0b count=%0d", rsp_id, rsp_match, rsp_timeout, match_count);
            end
        end
        m_prev_new = hc_newrdy;
        m_prev_chk = hc_checkrdy;
        prev_ldr   = ld_ready;
        prev_rr    = req_ready;
        prev_hash  = hc_hash;
    end

    // One stimulus cycle: judge the handshakes produced by the last drive,
    // then drive the next inputs.
    task automatic tick();
        int           w;
        logic [N-1:0] exp_grant;
        @(negedge clk);
        if (nrst) begin
            if (ld_ready) begin
                chk("ld_ready_needs_valid", 128'(drv_ld), 128'd1);
                chk("ld_beats_req", 128'(req_ready), 128'd0);
                chk("ld_hash_latched", hc_hash, drv_ld_hash);
                targets.push_back(drv_ld_hash);
                ld_pend = 0;
                $display("load   hash=%h", drv_ld_hash);
            end else if (req_ready != 0) begin
                w = -1;
                if (!drv_ld)
                    for (int k = 0; k < N; k++)
                        if (w < 0 && drv_valid[(ptr_m + k) % N]) w = (ptr_m + k) % N;
                exp_grant = '0;
                if (w >= 0) exp_grant[w] = 1'b1;
                chk("req_ready_grant", 128'(req_ready), 128'(exp_grant));
                if (w >= 0) begin
                    chk("chk_hash_latched", hc_hash, hold[w]);
                    sb.push_back('{id: IDW'(w), match: (!hc_dead && in_list(hold[w], 1'b0)), tmo: hc_dead});
                    $display("grant  id=%0d hash=%h", w, hold[w]);
                    pend[w] = 0;
                    ptr_m   = (w + 1) % N;
                    grants++;
                    grant_log.push_back(w);
                    if (keep_all) begin
                        pend[w] = 1;
                        hold[w] = rand128();
                    end
                end
            end
        end
        if (rand_mode) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 5) == 0) begin
                    pend[i] = 1;
                    if (targets.size() > 0 && $urandom_range(0, 2) == 0)
                        hold[i] = targets[$urandom_range(0, targets.size() - 1)];
                    else
                        hold[i] = rand128();
                end
            if (!ld_pend && $urandom_range(0, 39) == 0) begin
                ld_pend = 1;
                ld_hold = rand128();
            end
        end
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = pend[i];
            req_hash[128*i +: 128] = hold[i];
            drv_valid[i]           = pend[i];
        end
        ld_valid    = ld_pend;
        ld_hash     = ld_hold;
        drv_ld      = ld_pend;
        drv_ld_hash = ld_hold;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while (n < budget && (any_pend() || sb.size() != 0 || busy));
        chk("drain_within_budget", 128'(n < budget), 128'd1);
    endtask

    task automatic load(input logic [127:0] h);
        ld_pend = 1;
        ld_hold = h;
        drain(200);
    endtask

    task automatic submit(input int i, input logic [127:0] h);
        pend[i] = 1;
        hold[i] = h;
        drain(200);
    endtask

    task automatic check_reset_outputs();
        chk("rst_outputs", 128'({busy, ld_ready, req_ready, rsp_valid, rsp_id, rsp_match, rsp_timeout,
                                 hc_newrdy, hc_checkrdy, match_count}), 128'd0);
        chk("rst_hc_hash", hc_hash, 128'd0);
    endtask

    initial begin
        int n, g0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 0;
            hold[i] = '0;
        end
        nrst = 1'b0;
        repeat (3) tick();
        check_reset_outputs();
        nrst = 1'b1;

        load(128'h0CB6948805F797BF2A82807973B89537);
        load(128'h61FB34469B9989B01BE4E8630C52EED6);
        load(rand128());

        submit(2, 128'h61FB34469B9989B01BE4E8630C52EED6);
        chk("tp2_match_count", 128'(match_count), 128'd1);
        submit(1, 128'h7CE21F17C0AEE7FB9CEBA532D0546AD6);
        chk("tp3_match_count", 128'(match_count), 128'd1);

        // Stubbed checker never answers: timeout response.
        hc_dead = 1;
        submit(0, 128'h0CB6948805F797BF2A82807973B89537);

        // Reset while waiting for the result: the check is abandoned.
        pend[3] = 1;
        hold[3] = rand128();
        n = 0;
        while (!hc_checkrdy && n < 50) begin tick(); n++; end
        while (hc_checkrdy && n < 50) begin tick(); n++; end
        chk("reached_ck_wait", 128'(n < 50), 128'd1);
        tick();
        tick();
        chk("busy_in_ck_wait", 128'(busy), 128'd1);
        nrst = 1'b0;
        tick();
        check_reset_outputs();
        sb.delete();
        ptr_m       = 0;
        mc_model    = 0;
        exp_rsp_set = 0;
        nrst        = 1'b1;
        repeat (12) tick();
        hc_dead = 0;

        // Fairness: everyone keeps asking.
        grant_log.delete();
        g0       = grants;
        keep_all = 1;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1;
            hold[i] = rand128();
        end
        n = 0;
        while (grants < g0 + 8 && n < 400) begin tick(); n++; end
        keep_all = 0;
        drain(400);
        for (int k = 0; k < 8; k++)
            chk("fair_order", 128'((k < grant_log.size()) ? grant_log[k] : -1), 128'(k % 4));

        // Loader and requester 3 rise together: loader first.
        grant_log.delete();
        ld_pend = 1;
        ld_hold = rand128();
        pend[3] = 1;
        hold[3] = rand128();
        drain(200);
        chk("prio_req_after_store", 128'((grant_log.size() == 1) ? grant_log[0] : -1), 128'd3);

        // Random traffic against the reference model.
        g0        = grants;
        rand_mode = 1;
        n         = 0;
        while (grants < g0 + 40 && n < 4000) begin tick(); n++; end
        rand_mode = 0;
        chk("random_progress", 128'(grants >= g0 + 40), 128'd1);
        drain(2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
